regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy (scoreboard) bits,
// same-cycle write bypass, and an optional registered read path.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int REG_OUT  = 0,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wv;
  logic            sb_ok;

  logic [AW-1:0]       ra [NRD];
  logic [NRD*XLEN-1:0] rd_comb;
  logic [NRD-1:0]      rb_comb;

  // An address is usable when it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wa[w] = wr_addr_i[w*AW +: AW];
      wd[w] = wr_data_i[w*XLEN +: XLEN];
      wv[w] = wr_en_i[w] && addr_ok(wa[w]);
    end
    sb_ok = sb_set_i && addr_ok(sb_addr_i);
  end

  // Later write ports override earlier ones, so the highest-index port wins the bypass.
  always_comb begin
    rd_comb = '0;
    rb_comb = '0;
    for (int p = 0; p < NRD; p++) begin
      ra[p] = rd_addr_i[p*AW +: AW];
      if (addr_ok(ra[p])) begin
        rd_comb[p*XLEN +: XLEN] = regs[ra[p]];
        rb_comb[p]              = busy[ra[p]];
        for (int w = 0; w < NWR; w++) begin
          if (wv[w] && (wa[w] == ra[p])) begin
            rd_comb[p*XLEN +: XLEN] = wd[w];
            rb_comb[p]              = 1'b0;
          end
        end
      end
    end
  end

  // Set is applied after the write clears, so an issue to the same register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wv[w]) begin
          regs[wa[w]] <= wd[w];
          busy[wa[w]] <= 1'b0;
        end
      end
      if (sb_ok) busy[sb_addr_i] <= 1'b1;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [NRD*XLEN-1:0] rd_data_q;
      logic [NRD-1:0]      rd_busy_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q <= '0;
          rd_busy_q <= '0;
        end else begin
          rd_data_q <= rd_comb;
          rd_busy_q <= rb_comb;
        end
      end
      assign rd_data_o = rd_data_q;
      assign rd_busy_o = rd_busy_q;
    end else begin : g_comb_out
      assign rd_data_o = rd_comb;
      assign rd_busy_o = rb_comb;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: combinational, registered and reduced-size (NREGS=24) register
// files share one stimulus stream; expectations are hand-computed constants.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;

  logic [63:0] c_data, r_data, s_data;
  logic [1:0]  c_busy, r_busy, s_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_mp #(.REG_OUT(0)) u_comb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(c_data), .rd_busy_o(c_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr)
  );

  regfile_mp #(.REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(r_data), .rd_busy_o(r_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr)
  );

  regfile_mp #(.NREGS(24), .REG_OUT(0)) u_small (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(s_data), .rd_busy_o(s_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] en, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic sb, input logic [4:0] sba,
                        input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en   = en;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    sb_set  = sb;
    sb_addr = sba;
    rd_addr = {ra1, ra0};
  endtask

  task automatic rd(input logic [4:0] ra0, input logic [4:0] ra1);
    set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, ra0, ra1);
  endtask

  // Checks the combinational copy now, then the registered copy one edge later.
  task automatic cycle(input string tag, input logic [31:0] d0, input logic b0,
                       input logic [31:0] d1, input logic b1);
    #1;
    check({tag, "_c_d0"}, c_data[31:0],  d0);
    check({tag, "_c_b0"}, {31'b0, c_busy[0]}, {31'b0, b0});
    check({tag, "_c_d1"}, c_data[63:32], d1);
    check({tag, "_c_b1"}, {31'b0, c_busy[1]}, {31'b0, b1});
    exp_q.push_back(d0);
    exp_q.push_back({31'b0, b0});
    exp_q.push_back(d1);
    exp_q.push_back({31'b0, b1});
    @(posedge clk);
    #1;
    check({tag, "_r_d0"}, r_data[31:0],  exp_q.pop_front());
    check({tag, "_r_b0"}, {31'b0, r_busy[0]}, exp_q.pop_front());
    check({tag, "_r_d1"}, r_data[63:32], exp_q.pop_front());
    check({tag, "_r_b1"}, {31'b0, r_busy[1]}, exp_q.pop_front());
  endtask

  task automatic check_s(input string tag, input logic [31:0] d0, input logic b0,
                         input logic [31:0] d1, input logic b1);
    #1;
    check({tag, "_s_d0"}, s_data[31:0],  d0);
    check({tag, "_s_b0"}, {31'b0, s_busy[0]}, {31'b0, b0});
    check({tag, "_s_d1"}, s_data[63:32], d1);
    check({tag, "_s_b1"}, {31'b0, s_busy[1]}, {31'b0, b1});
  endtask

  initial begin
    // Reset with a write and an issue in flight: bypass visible, state discarded.
    rst = 1'b1;
    set_in(2'b01, 5'd3, 5'd0, 32'h0000AAAA, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
    @(posedge clk);
    #1;
    check("rst_bypass", c_data[31:0], 32'h0000AAAA);
    @(posedge clk);
    #1;
    check("rst_r_d", r_data[31:0] | r_data[63:32], 32'h0);
    check("rst_r_b", {30'b0, r_busy}, 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      cycle($sformatf("sweep%0d", a), 32'h0, 1'b0, 32'h0, 1'b0);
    end

    set_in(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    cycle("x5_wr", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    rd(5'd5, 5'd5);
    cycle("x5_rd", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);

    set_in(2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5);
    cycle("x7_wr", 32'h22, 1'b0, 32'hDEADBEEF, 1'b0);
    rd(5'd7, 5'd7);
    cycle("x7_rd", 32'h22, 1'b0, 32'h22, 1'b0);

    set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    cycle("x9_set", 32'h0, 1'b0, 32'h0, 1'b0);
    rd(5'd9, 5'd8);
    cycle("x9_busy", 32'h0, 1'b1, 32'h0, 1'b0);
    set_in(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    cycle("x9_wr_set", 32'h99, 1'b0, 32'h99, 1'b0);
    rd(5'd9, 5'd9);
    cycle("x9_still", 32'h99, 1'b1, 32'h99, 1'b1);
    set_in(2'b10, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 5'd0, 5'd8, 5'd9);
    cycle("x9_wr", 32'h0, 1'b0, 32'h77, 1'b0);
    rd(5'd9, 5'd9);
    cycle("x9_clr", 32'h77, 1'b0, 32'h77, 1'b0);

    set_in(2'b10, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd7);
    cycle("x0_wr", 32'h0, 1'b0, 32'h22, 1'b0);
    rd(5'd0, 5'd0);
    cycle("x0_rd", 32'h0, 1'b0, 32'h0, 1'b0);

    set_in(2'b11, 5'd10, 5'd11, 32'h1010, 32'h1111, 1'b0, 5'd0, 5'd11, 5'd10);
    cycle("dual_wr", 32'h1111, 1'b0, 32'h1010, 1'b0);
    rd(5'd10, 5'd11);
    cycle("dual_rd", 32'h1010, 1'b0, 32'h1111, 1'b0);

    // Addresses 24..31 do not exist in the reduced instance.
    set_in(2'b11, 5'd30, 5'd23, 32'h5, 32'h23, 1'b1, 5'd30, 5'd30, 5'd23);
    check_s("oor_wr", 32'h0, 1'b0, 32'h23, 1'b0);
    cycle("x30_wr", 32'h5, 1'b0, 32'h23, 1'b0);
    rd(5'd30, 5'd31);
    check_s("oor_rd", 32'h0, 1'b0, 32'h0, 1'b0);
    cycle("x30_rd", 32'h5, 1'b1, 32'h0, 1'b0);
    set_in(2'b01, 5'd31, 5'd0, 32'h31313131, 32'h0, 1'b1, 5'd31, 5'd31, 5'd23);
    cycle("x31_wr", 32'h31313131, 1'b0, 32'h23, 1'b0);
    rd(5'd31, 5'd23);
    check_s("x23_rd", 32'h0, 1'b0, 32'h23, 1'b0);
    cycle("x31_rd", 32'h31313131, 1'b1, 32'h23, 1'b0);

    set_in(2'b01, 5'd3, 5'd0, 32'h1234, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
    cycle("x3_wr", 32'h1234, 1'b0, 32'h77, 1'b0);

    // Reset in the middle of traffic: everything returns to zero on that edge.
    rd(5'd3, 5'd30);
    rst = 1'b1;
    #1;
    check("pre_rst_d0", c_data[31:0], 32'h1234);
    check("pre_rst_b1", {31'b0, c_busy[1]}, 32'h1);
    @(posedge clk);
    #1;
    check("mid_rst_r_d0", r_data[31:0], 32'h0);
    check("mid_rst_r_d1", r_data[63:32], 32'h0);
    check("mid_rst_r_b", {30'b0, r_busy}, 32'h0);
    check("mid_rst_c_d0", c_data[31:0], 32'h0);
    check("mid_rst_c_b1", {31'b0, c_busy[1]}, 32'h0);
    rst = 1'b0;
    rd(5'd9, 5'd31);
    cycle("post_rst", 32'h0, 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
